// File: rtl/nes_pad_pkg.sv
// Shared types for the NES pad responder: FSM state encoding and the
// button bit positions inside the parallel button word.
`timescale 1ns/1ps
package nes_pad_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

endpackage

// File: rtl/nes_pad_responder_if.sv
// Three-wire NES controller link. The host (controller reader) drives
// latch and shift clock; the pad answers on the active-low data line.
`timescale 1ns/1ps
interface nes_pad_responder_if;
  logic nes_latch;
  logic nes_clk;
  logic nes_data;

  modport master (output nes_latch, output nes_clk, input nes_data);
  modport slave  (input nes_latch, input nes_clk, output nes_data);
endinterface

// File: rtl/nes_pad_sync.sv
// Multi-flop synchroniser for one asynchronous host strobe, followed by
// a single edge-detect flop that yields one-clk rise/fall events.
`timescale 1ns/1ps
module nes_pad_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_last;

  // Shift the pin through the synchroniser chain and remember the last level.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour, which is what makes the chain a chain.
  // NOTE: async reset clears only control flops; there are no memories here.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= '0;
      r_last <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_last <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_level = r_sync[SYNC_STAGES-1];
  assign o_rise  = r_sync[SYNC_STAGES-1] & ~r_last;
  assign o_fall  = ~r_sync[SYNC_STAGES-1] & r_last;

endmodule

// File: rtl/nes_pad_responder.sv
// Device end of the NES controller link: emulates the pad's 4021 shift
// register. Latch loads the (active-low) button word, each host clock rise
// shifts one bit out, and the frame completes after N_BITS shifts.
// Optional feature macro: NES_PAD_TURBO_EN (turbo auto-fire on A/B).
`timescale 1ns/1ps
module nes_pad_responder
  import nes_pad_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int N_BITS      = 8,
  parameter int TURBO_DIV   = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [N_BITS-1:0]   buttons,
  input  logic [1:0]          turbo,
  nes_pad_responder_if.slave  link,
  output logic                frame_done,
  output logic [4:0]          bit_idx
);

  if (N_BITS < 2 || N_BITS > 16) begin : g_bad_n_bits
    $error("nes_pad_responder: N_BITS must be in 2..16");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync_stages
    $error("nes_pad_responder: SYNC_STAGES must be >= 2");
  end

  logic              w_latch_s;
  logic              w_latch_fall;
  logic              w_latch_rise_unused;
  logic              w_clk_rise;
  logic              w_clk_level_unused;
  logic              w_clk_fall_unused;
  logic [N_BITS-1:0] w_load_word;

  state_e            r_state;
  logic [N_BITS-1:0] r_shift;
  logic              r_data;
  logic              r_done;
  logic [4:0]        r_idx;

  nes_pad_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_latch (
    .clk     (clk),
    .reset_n (reset_n),
    .i_async (link.nes_latch),
    .o_level (w_latch_s),
    .o_rise  (w_latch_rise_unused),
    .o_fall  (w_latch_fall)
  );

  nes_pad_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clk (
    .clk     (clk),
    .reset_n (reset_n),
    .i_async (link.nes_clk),
    .o_level (w_clk_level_unused),
    .o_rise  (w_clk_rise),
    .o_fall  (w_clk_fall_unused)
  );

`ifdef NES_PAD_TURBO_EN
  localparam int TCW = (TURBO_DIV > 1) ? $clog2(TURBO_DIV) : 1;

  logic [TCW-1:0] r_turbo_cnt;
  logic           r_turbo_phase;

  // Count latch falling edges; flip the turbo phase every TURBO_DIV of them.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_turbo_cnt   <= '0;
      r_turbo_phase <= 1'b0;
    end else if (w_latch_fall) begin
      if (r_turbo_cnt == TCW'(TURBO_DIV - 1)) begin
        r_turbo_cnt   <= '0;
        r_turbo_phase <= ~r_turbo_phase;
      end else begin
        r_turbo_cnt <= r_turbo_cnt + 1'b1;
      end
    end
  end

  // Active-low load word; turbo buttons read as released during phase 1.
  // NOTE: the default assignment first keeps this combinational block latch-free.
  always_comb begin
    w_load_word = ~buttons;
    if (r_turbo_phase) begin
      if (turbo[0]) w_load_word[BTN_A] = 1'b1;
      if (turbo[1]) w_load_word[BTN_B] = 1'b1;
    end
  end
`else
  logic w_turbo_unused;

  assign w_load_word    = ~buttons;
  assign w_turbo_unused = ^{turbo, TURBO_DIV[0]};
`endif

  // Pad FSM: latch has priority from any state, host clock rises shift in SHIFT.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_shift <= '1;
      r_data  <= 1'b1;
      r_done  <= 1'b0;
      r_idx   <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_latch_s) begin
        r_state <= LOAD;
        r_shift <= w_load_word;
        r_data  <= w_load_word[0];
        r_idx   <= '0;
      end else begin
        case (r_state)
          IDLE: r_data <= 1'b1;
          LOAD: begin
            // The word loaded on the last latched cycle stays frozen.
            if (w_latch_fall) r_state <= SHIFT;
          end
          SHIFT: begin
            if (w_clk_rise) begin
              r_shift <= {1'b1, r_shift[N_BITS-1:1]};
              r_idx   <= r_idx + 5'd1;
              if (r_idx == 5'(N_BITS - 1)) begin
                r_done  <= 1'b1;
                r_data  <= 1'b1;
                r_state <= DONE;
              end else begin
                r_data <= r_shift[1];
              end
            end
          end
          DONE:    r_data  <= 1'b1;
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign link.nes_data = r_data;
  assign frame_done    = r_done;
  assign bit_idx       = r_idx;

endmodule

// File: tb/tb_nes_pad_responder.sv
// Self-checking bench for nes_pad_responder: directed host frames plus
// randomized frames, checked against a frame-level model of the pad.
`timescale 1ns/1ps
module tb_nes_pad_responder;

  localparam int SYNC_STAGES = 2;
  localparam int N_BITS      = 8;
  localparam int TURBO_DIV   = 4;
`ifdef NES_PAD_TURBO_EN
  localparam bit TURBO_EN = 1'b1;
`else
  localparam bit TURBO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  buttons = '0;
  logic [1:0]  turbo = '0;
  logic        frame_done;
  logic [4:0]  bit_idx;

  nes_pad_responder_if link ();

  nes_pad_responder #(
    .SYNC_STAGES (SYNC_STAGES),
    .N_BITS      (N_BITS),
    .TURBO_DIV   (TURBO_DIV)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .buttons    (buttons),
    .turbo      (turbo),
    .link       (link.slave),
    .frame_done (frame_done),
    .bit_idx    (bit_idx)
  );

  always #20 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;
  int n_falls = 0;

  always @(negedge clk) if (frame_done === 1'b1) done_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pressed-button word the pad should report for a frame whose latch fall is
  // the (falls_before+1)-th since reset.
  function automatic logic [7:0] model_pressed(input logic [7:0] btn, input logic [1:0] tb_turbo,
                                               input int falls_before);
    logic [7:0] p;
    bit         phase;
    p     = btn;
    phase = ((falls_before / TURBO_DIV) % 2) == 1;
    if (TURBO_EN && phase) begin
      if (tb_turbo[0]) p[0] = 1'b0;
      if (tb_turbo[1]) p[1] = 1'b0;
    end
    return p;
  endfunction

  task automatic latch_frame(input logic [7:0] btn, input int latch_ns, input string tag,
                             output logic [7:0] pressed);
    logic e;
    buttons = btn;
    pressed = model_pressed(btn, turbo, n_falls);
    link.nes_latch = 1'b1;
    #(latch_ns);
    @(negedge clk);
    e = ~pressed[0];
    check($sformatf("%s_load_data", tag), link.nes_data, e);
    check($sformatf("%s_load_idx", tag), bit_idx, 0);
    link.nes_latch = 1'b0;
    n_falls++;
  endtask

  // Read n bits: sample before each host clock rise, then pulse the clock.
  task automatic shift_read(input logic [7:0] pressed, input int n, input int half_ns,
                            input string tag);
    int   d0;
    logic e;
    d0 = done_cnt;
    for (int i = 0; i < n; i++) begin
      #(half_ns);
      @(negedge clk);
      e = (i < 8) ? ~pressed[i] : 1'b1;
      check($sformatf("%s_bit%0d", tag, i), link.nes_data, e);
      check($sformatf("%s_idx%0d", tag, i), bit_idx, (i < 8) ? i : 8);
      link.nes_clk = 1'b1;
      #(half_ns);
      link.nes_clk = 1'b0;
    end
    #(half_ns);
    @(negedge clk);
    e = (n < 8) ? ~pressed[n] : 1'b1;
    check($sformatf("%s_end_data", tag), link.nes_data, e);
    check($sformatf("%s_end_idx", tag), bit_idx, (n < 8) ? n : 8);
    check($sformatf("%s_done_cnt", tag), done_cnt - d0, (n >= 8) ? 1 : 0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset_n = 1'b0;
    #5;
    check("rst_async_data", link.nes_data, 1);
    check("rst_async_idx", bit_idx, 0);
    @(negedge clk);
    reset_n = 1'b1;
    n_falls = 0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] p;
    logic       e;
    int         d;
    link.nes_latch = 1'b0;
    link.nes_clk   = 1'b0;

    repeat (4) @(negedge clk);
    check("reset_data", link.nes_data, 1);
    check("reset_idx", bit_idx, 0);
    check("reset_done", frame_done, 0);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    check("idle_data", link.nes_data, 1);

    // 1: A pressed only, slow host timing.
    latch_frame(8'h01, 12000, "t1", p);
    shift_read(p, 8, 3000, "t1");

    // 2: all pressed, two extra clocks after the frame.
    latch_frame(8'hFF, 12000, "t2", p);
    shift_read(p, 10, 3000, "t2");

    // 3: buttons change during latch, then again after the latch falls.
    buttons = 8'h00;
    link.nes_latch = 1'b1;
    #5000;
    buttons = 8'h80;
    repeat (100) @(negedge clk);
    link.nes_latch = 1'b0;
    p = model_pressed(8'h80, turbo, n_falls);
    n_falls++;
    #1000;
    buttons = 8'h5A;
    shift_read(p, 8, 3000, "t3");

    // 4: re-latch after three shifts aborts the frame.
    latch_frame(8'h0F, 4000, "t4a", p);
    shift_read(p, 3, 1000, "t4a");
    d = done_cnt;
    buttons = 8'h0E;
    link.nes_latch = 1'b1;
    repeat (SYNC_STAGES + 2) @(posedge clk);
    @(negedge clk);
    check("t4_relatch_idx", bit_idx, 0);
    check("t4_relatch_data", link.nes_data, 1);
    #2000;
    link.nes_latch = 1'b0;
    p = model_pressed(8'h0E, turbo, n_falls);
    n_falls++;
    check("t4_abort_no_done", done_cnt - d, 0);
    shift_read(p, 8, 1000, "t4b");

    // 5: reset mid-SHIFT, clocks ignored in IDLE, then a clean frame.
    latch_frame(8'hA5, 2000, "t5a", p);
    shift_read(p, 3, 1000, "t5a");
    pulse_reset();
    @(negedge clk);
    check("t5_idle_data", link.nes_data, 1);
    check("t5_idle_idx", bit_idx, 0);
    link.nes_clk = 1'b1;
    #500;
    link.nes_clk = 1'b0;
    #500;
    @(negedge clk);
    check("t5_idle_clk_idx", bit_idx, 0);
    check("t5_idle_clk_data", link.nes_data, 1);
    latch_frame(8'h3C, 2000, "t5b", p);
    shift_read(p, 8, 1000, "t5b");

    // Randomized frames, including partial (aborted) ones.
    for (int f = 0; f < 12; f++) begin
      turbo = 2'($urandom);
      latch_frame(8'($urandom), int'($urandom_range(400, 1500)), $sformatf("r%0d", f), p);
      shift_read(p, int'($urandom_range(3, 10)), int'($urandom_range(300, 800)),
                 $sformatf("r%0d", f));
    end
    turbo = 2'b00;

`ifdef NES_PAD_TURBO_EN
    // 6: turbo A over 16 frames from a fresh phase.
    pulse_reset();
    turbo = 2'b01;
    for (int f = 0; f < 16; f++) begin
      latch_frame(8'h01, 1000, $sformatf("t6f%0d", f), p);
      #300;
      @(negedge clk);
      e = ((f / 4) % 2 == 0) ? 1'b0 : 1'b1;
      check($sformatf("t6_a_frame%0d", f + 1), link.nes_data, e);
      shift_read(p, 8, 500, $sformatf("t6f%0d", f));
    end
    turbo = 2'b00;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
